// File: rtl/alu_ctrl_issue_pkg.sv
// Shared constants and types for the ALU control issue block: ALU operation
// codes, MIPS opcode/funct values and the skid-buffer occupancy encoding.
package alu_ctrl_issue_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_CTRL_W = 5;

  // ALU operation codes understood by the EX-stage ALU
  localparam logic [4:0] ALU_AND = 5'd0;
  localparam logic [4:0] ALU_OR  = 5'd1;
  localparam logic [4:0] ALU_ADD = 5'd2;
  localparam logic [4:0] ALU_SUB = 5'd6;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  // Number of valid entries held between ID and EX
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/alu_ctrl_issue_decode.sv
// Pure combinational MIPS decode: instruction word -> ALU code, operand-B
// select, extended immediate and an illegal flag. Unsupported encodings
// fall back to a harmless add with a zero immediate so no X ever leaves.
module alu_ctrl_issue_decode
  import alu_ctrl_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic [DATA_W-1:0] instr,
  output logic [CTRL_W-1:0] code,
  output logic              src_imm,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);

  logic [5:0]        op;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic              unused_reg_fields;

  assign op       = instr[31:26];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign imm_sext = {{(DATA_W-16){imm16[15]}}, imm16};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm16};

  // Register specifiers are consumed by the register file, not here
  assign unused_reg_fields = ^instr[25:16];

  // Opcode/funct table lookup with a safe fallback for anything unknown
  always_comb begin
    code    = CTRL_W'(ALU_ADD);
    src_imm = 1'b0;
    imm     = {DATA_W{1'b0}};
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: code = CTRL_W'(ALU_ADD);
          FN_SUB, FN_SUBU: code = CTRL_W'(ALU_SUB);
          FN_AND:          code = CTRL_W'(ALU_AND);
          FN_OR:           code = CTRL_W'(ALU_OR);
          default:         illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
        code    = CTRL_W'(ALU_ADD);
        src_imm = 1'b1;
        imm     = imm_sext;
      end
      OP_ANDI: begin
        code    = CTRL_W'(ALU_AND);
        src_imm = 1'b1;
        imm     = imm_zext;
      end
      OP_ORI: begin
        code    = CTRL_W'(ALU_OR);
        src_imm = 1'b1;
        imm     = imm_zext;
      end
      OP_BEQ, OP_BNE: begin
        code = CTRL_W'(ALU_SUB);
        imm  = imm_sext;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ID/EX issue stage: decodes the incoming instruction and holds it in a
// 2-entry skid buffer (head + skid). EX sees only the head register, so
// outputs are glitch-free and stay put while EX stalls.
module alu_ctrl_issue
  import alu_ctrl_issue_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] sig_alu_control,
  output logic              out_alu_src_imm,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_illegal
);

  localparam int ENT_W = CTRL_W + DATA_W + 2;
  // Entry layout: {code, src_imm, imm, illegal}
  localparam logic [ENT_W-1:0] RESET_ENT = {CTRL_W'(ALU_ADD), 1'b0, {DATA_W{1'b0}}, 1'b0};

  logic [CTRL_W-1:0] dec_code;
  logic              dec_src_imm;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;
  logic [ENT_W-1:0]  dec_ent;

  logic [ENT_W-1:0]  head_r;
  logic [ENT_W-1:0]  skid_r;
  occ_t              state_r;
  occ_t              state_nxt;

  logic              accept;
  logic              pop;
  logic              load_head_dec;
  logic              load_head_skid;
  logic              load_skid;

  alu_ctrl_issue_decode #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .instr   (in_instr),
    .code    (dec_code),
    .src_imm (dec_src_imm),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign dec_ent = {dec_code, dec_src_imm, dec_imm, dec_illegal};

  // Handshake flags come from the state register only, never from out_ready
  assign in_ready  = (state_r != OCC_FULL);
  assign out_valid = (state_r != OCC_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Occupancy next-state and register load selects; flush wins over everything
  always_comb begin
    state_nxt      = state_r;
    load_head_dec  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state_r)
        OCC_EMPTY: begin
          if (accept) begin
            load_head_dec = 1'b1;
            state_nxt     = OCC_ONE;
          end else begin
            state_nxt = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (accept && pop) begin
            load_head_dec = 1'b1;
            state_nxt     = OCC_ONE;
          end else if (accept) begin
            load_skid = 1'b1;
            state_nxt = OCC_FULL;
          end else if (pop) begin
            state_nxt = OCC_EMPTY;
          end else begin
            state_nxt = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            load_head_skid = 1'b1;
            state_nxt      = OCC_ONE;
          end else begin
            state_nxt = OCC_FULL;
          end
        end
        default: state_nxt = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= OCC_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Head/skid data registers; head holds its value when the buffer drains
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r <= RESET_ENT;
      skid_r <= RESET_ENT;
    end else begin
      if (load_head_dec) begin
        head_r <= dec_ent;
      end else if (load_head_skid) begin
        head_r <= skid_r;
      end
      if (load_skid) begin
        skid_r <= dec_ent;
      end
    end
  end

  assign {sig_alu_control, out_alu_src_imm, out_imm, out_illegal} = head_r;

endmodule
